// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry full adder with one-cycle latency.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // One full-adder cell per bit; the carry ripples LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed and random checks for full_adder_unit at WIDTH=1 and WIDTH=8.
// Includes the ovf output when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       a1, b1, c1;
  logic       ov1, s1, co1;
  logic [7:0] a8, b8;
  logic       c8;
  logic       ov8, co8;
  logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
  logic       of1, of8;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_fa1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (valid),
    .a        (a1),
    .b        (b1),
    .cin      (c1),
    .out_valid(ov1),
    .sum      (s1),
    .carry    (co1)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf      (of1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_fa8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (valid),
    .a        (a8),
    .b        (b8),
    .cin      (c8),
    .out_valid(ov8),
    .sum      (s8),
    .carry    (co8)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf      (of8)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed a+b+cin for (a,b,cin) = 3'b000 .. 3'b111.
  logic [1:0] exp1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2,
                           2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    logic [2:0] v;
    logic [8:0] e;
    rst   = 1'b1;
    valid = 1'b0;
    {a1, b1, c1} = 3'b000;
    {a8, b8, c8} = '0;
    #2;
    check("rst_init1", {ov1, co1, s1}, 3'b000);
    check("rst_init8", {ov8, co8, s8}, 10'h0);
    step();
    rst = 1'b0;

    // load a nonzero result, then reset between edges
    valid = 1'b1;
    {a1, b1, c1} = 3'b111;
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
    step();
    check("pre_rst1", {ov1, co1, s1}, 3'b111);
    check("pre_rst8", {ov8, co8, s8}, {2'b11, 8'h00});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst1", {ov1, co1, s1}, 3'b000);
    check("async_rst8", {ov8, co8, s8}, 10'h0);
    step();
    check("rst_hold1", {ov1, co1, s1}, 3'b000);
    check("rst_hold8", {ov8, co8, s8}, 10'h0);
`ifdef FULL_ADDER_OVF_EN
    check("rst_ovf", {of1, of8}, 2'b00);
`endif
    rst = 1'b0;

    // WIDTH=1 exhaustive, back to back
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      step();
      check($sformatf("w1_%b", v), {ov1, co1, s1}, {1'b1, exp1[i]});
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w1_ovf_%b", v), of1, exp1[i][1] ^ v[0]);
`endif
    end

    // hold with in_valid low, including X inputs
    {a1, b1, c1} = 3'b110;
    step();
    check("hold_load", {ov1, co1, s1}, 3'b110);
    valid = 1'b0;
    {a1, b1, c1} = 3'b000;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    step();
    check("hold_idle", {ov1, co1, s1}, 3'b010);
    a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
    a8 = 'x; b8 = 'x; c8 = 1'bx;
    step();
    check("hold_x1", {ov1, co1, s1}, 3'b010);
    check("hold_x8", {ov8, co8, s8}, {2'b01, 8'h00});
    {a1, b1, c1} = 3'b000;

    // WIDTH=8 boundaries
    valid = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step();
    check("w8_ffff1", {ov8, co8, s8}, {2'b11, 8'hFF});
`ifdef FULL_ADDER_OVF_EN
    check("w8_ffff1_ovf", of8, 1'b0);
`endif
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    step();
    check("w8_8080", {ov8, co8, s8}, {2'b11, 8'h00});
`ifdef FULL_ADDER_OVF_EN
    check("w8_8080_ovf", of8, 1'b1);
`endif
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    step();
    check("w8_7f01", {ov8, co8, s8}, {2'b10, 8'h80});
`ifdef FULL_ADDER_OVF_EN
    check("w8_7f01_ovf", of8, 1'b1);
`endif
    a8 = 8'h0F; b8 = 8'hF0; c8 = 1'b1;
    step();
    check("w8_0ff0", {ov8, co8, s8}, {2'b11, 8'h00});

    // WIDTH=8 random back to back
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      e  = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      step();
      check($sformatf("rnd%0d", i), {ov8, co8, s8}, {1'b1, e});
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("rnd_ovf%0d", i), of8,
            (a8[7] == b8[7]) && (e[7] != a8[7]));
`endif
    end

    // reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst", {ov8, co8, s8}, 10'h0);
    step();
    check("mid_rst_hold", {ov8, co8, s8}, 10'h0);
    rst = 1'b0;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    #1;
    check("post_rst_idle", ov8, 1'b0);
    step();
    check("post_rst_first", {ov8, co8, s8}, {2'b10, 8'h47});
    valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
